// File: rtl/pwm_pkg.sv
// Shared types for the six-step commutation path: FSM state encoding, sector
// arithmetic and the per-sector phase duty pattern.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int unsigned SECTORS     = 6;
  localparam logic [2:0]  SECTOR_LAST = 3'(SECTORS - 1);

  // Which level a phase is driven to: low side, mid-rail (floating phase), or the drive duty.
  typedef enum logic [1:0] {
    DSEL_L = 2'd0,
    DSEL_N = 2'd1,
    DSEL_D = 2'd2
  } dsel_t;

  typedef struct packed {
    dsel_t a;
    dsel_t b;
    dsel_t c;
  } phase_sel_t;

  function automatic phase_sel_t sector_pattern(input logic [2:0] sector);
    case (sector)
      3'd0:    return '{a: DSEL_D, b: DSEL_L, c: DSEL_N};
      3'd1:    return '{a: DSEL_D, b: DSEL_N, c: DSEL_L};
      3'd2:    return '{a: DSEL_N, b: DSEL_D, c: DSEL_L};
      3'd3:    return '{a: DSEL_L, b: DSEL_D, c: DSEL_N};
      3'd4:    return '{a: DSEL_L, b: DSEL_N, c: DSEL_D};
      3'd5:    return '{a: DSEL_N, b: DSEL_L, c: DSEL_D};
      default: return '{a: DSEL_L, b: DSEL_L, c: DSEL_L};
    endcase
  endfunction

  function automatic logic [2:0] sector_step(input logic [2:0] sector, input logic fwd);
    if (fwd) return (sector >= SECTOR_LAST) ? 3'd0 : sector + 3'd1;
    return (sector == 3'd0) ? SECTOR_LAST : sector - 3'd1;
  endfunction

  function automatic logic is_active(input state_t s);
    return (s == ST_ALIGN) || (s == ST_RAMP) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/commutation_table.sv
// Combinational sector-to-duty map: clamps the drive duty to the PWM period and
// places drive, mid-rail and low levels on the three phases.
module commutation_table
  import pwm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   sector,
  input  logic [W-1:0] duty,
  input  logic [W-1:0] period,
  output logic [W-1:0] duty_0,
  output logic [W-1:0] duty_1,
  output logic [W-1:0] duty_2
);

  logic [W-1:0] d_clamped;
  logic [W-1:0] n_level;
  phase_sel_t   sel;

  function automatic logic [W-1:0] pick(input dsel_t s, input logic [W-1:0] d,
                                        input logic [W-1:0] n);
    case (s)
      DSEL_D:  return d;
      DSEL_N:  return n;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    d_clamped = (duty > period) ? period : duty;
    n_level   = period >> 1;
    sel       = sector_pattern(sector);
    duty_0    = pick(sel.a, d_clamped, n_level);
    duty_1    = pick(sel.b, d_clamped, n_level);
    duty_2    = pick(sel.c, d_clamped, n_level);
  end

endmodule

// File: rtl/six_step_commutator.sv
// Open-loop six-step BLDC sequencer: align, step-period ramp, steady commutation,
// with stop and fault shutdown. Drives the three-phase PWM block's duties/enable.
module six_step_commutator
  import pwm_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Stop,
  input  logic         Fault,
  input  logic         FaultClear,
  input  logic         Direction,
  input  logic [W-1:0] Period,
  input  logic [W-1:0] DutyCmd,
  input  logic [W-1:0] AlignDuty,
  input  logic [W-1:0] AlignTicks,
  input  logic [W-1:0] RampStartTicks,
  input  logic [W-1:0] RampDecTicks,
  input  logic [W-1:0] StepTicks,
  output logic [W-1:0] Duty_0,
  output logic [W-1:0] Duty_1,
  output logic [W-1:0] Duty_2,
  output logic         Enable,
  output logic [2:0]   Sector,
  output logic [2:0]   State,
  output logic         StepStrobe
);

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state_q, state_d;
  logic [2:0]   sector_q;
  logic         dir_q;
  logic [W-1:0] step_cnt, cur_ticks, align_cnt;
  logic [W-1:0] eff_ticks, align_last, ramp_sub, ramp_next, duty_src;
  logic [W-1:0] tbl_0, tbl_1, tbl_2;
  logic         step_done, align_done, commute, start_run, stepping;

  // Zero-length step/align counts behave as one clock.
  always_comb begin
    eff_ticks  = (cur_ticks == '0) ? ONE : cur_ticks;
    step_done  = (step_cnt >= eff_ticks - ONE);
    align_last = (AlignTicks == '0) ? '0 : AlignTicks - ONE;
    align_done = (align_cnt >= align_last);
    ramp_sub   = (cur_ticks > RampDecTicks) ? cur_ticks - RampDecTicks : '0;
    ramp_next  = (ramp_sub < StepTicks) ? StepTicks : ramp_sub;
    duty_src   = (state_q == ST_ALIGN) ? AlignDuty : DutyCmd;
  end

  // NOTE: state_d and commute get defaults before the case so no path leaves them
  // unassigned; a missing default in always_comb infers a latch.
  always_comb begin
    state_d = state_q;
    commute = 1'b0;
    case (state_q)
      ST_IDLE:  if (Start && !Stop) state_d = ST_ALIGN;
      ST_ALIGN: if (align_done) state_d = ST_RAMP;
      ST_RAMP: begin
        if (step_done) begin
          commute = 1'b1;
          if (ramp_next == StepTicks) state_d = ST_RUN;
        end
      end
      ST_RUN:   commute = step_done;
      ST_FAULT: if (FaultClear && !Fault) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (Stop && is_active(state_q)) begin
      state_d = ST_IDLE;
      commute = 1'b0;
    end
    if (Fault) begin
      state_d = ST_FAULT;
      commute = 1'b0;
    end
  end

  assign start_run = (state_q == ST_IDLE) && (state_d == ST_ALIGN);
  assign stepping  = (state_q inside {ST_RAMP, ST_RUN}) && (state_d inside {ST_RAMP, ST_RUN});

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      Enable     <= 1'b0;
      StepStrobe <= 1'b0;
      sector_q   <= '0;
      dir_q      <= 1'b0;
      step_cnt   <= '0;
      cur_ticks  <= '0;
      align_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      Enable     <= is_active(state_d);
      StepStrobe <= commute;
      if (start_run) begin
        sector_q  <= '0;
        dir_q     <= Direction;
        step_cnt  <= '0;
        cur_ticks <= RampStartTicks;
        align_cnt <= '0;
      end else begin
        if (state_q == ST_ALIGN) align_cnt <= align_cnt + ONE;
        if (commute) begin
          step_cnt  <= '0;
          sector_q  <= sector_step(sector_q, dir_q);
          cur_ticks <= (state_q == ST_RAMP) ? ramp_next : StepTicks;
        end else if (stepping) begin
          step_cnt <= step_cnt + ONE;
        end
      end
    end
  end

  commutation_table #(.W(W)) u_table (
    .sector (sector_q),
    .duty   (duty_src),
    .period (Period),
    .duty_0 (tbl_0),
    .duty_1 (tbl_1),
    .duty_2 (tbl_2)
  );

  // Duties lag sector/duty changes by one clock, but drop to zero together with Enable.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Duty_0 <= '0;
      Duty_1 <= '0;
      Duty_2 <= '0;
    end else if (is_active(state_q) && is_active(state_d)) begin
      Duty_0 <= tbl_0;
      Duty_1 <= tbl_1;
      Duty_2 <= tbl_2;
    end else begin
      Duty_0 <= '0;
      Duty_1 <= '0;
      Duty_2 <= '0;
    end
  end

  assign Sector = sector_q;
  assign State  = state_q;

endmodule

// File: tb/tb_six_step_commutator.sv
// Bench for six_step_commutator: table of expected commutations fed through a
// scoreboard queue, plus hand-written reset, stop and fault sequences.
module tb_six_step_commutator;

  localparam int W = 32;
  localparam logic [2:0] IDLE = 3'd0, ALIGN = 3'd1, RAMP = 3'd2, RUN = 3'd3, FLT = 3'd4;

  logic         Clk, Reset_n, Start, Stop, Fault, FaultClear, Direction;
  logic [W-1:0] Period, DutyCmd, AlignDuty, AlignTicks, RampStartTicks, RampDecTicks, StepTicks;
  logic [W-1:0] Duty_0, Duty_1, Duty_2;
  logic         Enable, StepStrobe;
  logic [2:0]   Sector, State;

  six_step_commutator #(.W(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stop(Stop), .Fault(Fault),
    .FaultClear(FaultClear), .Direction(Direction), .Period(Period), .DutyCmd(DutyCmd),
    .AlignDuty(AlignDuty), .AlignTicks(AlignTicks), .RampStartTicks(RampStartTicks),
    .RampDecTicks(RampDecTicks), .StepTicks(StepTicks), .Duty_0(Duty_0), .Duty_1(Duty_1),
    .Duty_2(Duty_2), .Enable(Enable), .Sector(Sector), .State(State), .StepStrobe(StepStrobe)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      tag;
    int         phase;
    int         gap;
    logic [2:0] sector;
    logic [2:0] state;
    bit         chk_duty;
    logic [W-1:0] d0, d1, d2;
  } step_vec_t;

  step_vec_t vec[$];
  step_vec_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int since    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] st, input logic [2:0] sec,
                           input logic en, input logic stb,
                           input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
    check({tag, ".state"}, 32'(State), 32'(st));
    check({tag, ".sector"}, 32'(Sector), 32'(sec));
    check({tag, ".enable"}, 32'(Enable), 32'(en));
    check({tag, ".strobe"}, 32'(StepStrobe), 32'(stb));
    check({tag, ".duty0"}, Duty_0, d0);
    check({tag, ".duty1"}, Duty_1, d1);
    check({tag, ".duty2"}, Duty_2, d2);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    since++;
  endtask

  task automatic add_vec(input string tag, input int phase, input int gap, input logic [2:0] sec,
                         input logic [2:0] st, input bit cd,
                         input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
    step_vec_t v;
    v.tag = tag; v.phase = phase; v.gap = gap; v.sector = sec; v.state = st;
    v.chk_duty = cd; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    vec.push_back(v);
  endtask

  task automatic load_phase(input int phase);
    foreach (vec[i]) if (vec[i].phase == phase) exp_q.push_back(vec[i]);
  endtask

  // Pops each expected commutation and waits (bounded) for the matching strobe.
  task automatic run_steps();
    step_vec_t e;
    int budget;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      budget = 200;
      do begin
        tick();
        budget--;
      end while (!StepStrobe && budget > 0);
      check({e.tag, ".strobe_seen"}, 32'(StepStrobe), 32'd1);
      check({e.tag, ".gap"}, 32'(since), 32'(e.gap));
      since = 0;
      check({e.tag, ".sector"}, 32'(Sector), 32'(e.sector));
      check({e.tag, ".state"}, 32'(State), 32'(e.state));
      check({e.tag, ".enable"}, 32'(Enable), 32'd1);
      if (e.chk_duty) begin
        tick();
        check({e.tag, ".strobe_drop"}, 32'(StepStrobe), 32'd0);
        check({e.tag, ".duty0"}, Duty_0, e.d0);
        check({e.tag, ".duty1"}, Duty_1, e.d1);
        check({e.tag, ".duty2"}, Duty_2, e.d2);
      end
    end
  endtask

  initial begin
    // Phase 1: align/ramp 40,30,20 then one steady step of 20.
    add_vec("ramp_s1", 1, 40, 3'd1, RAMP, 0, 0, 0, 0);
    add_vec("ramp_s2", 1, 30, 3'd2, RUN,  0, 0, 0, 0);
    add_vec("run_s3",  1, 20, 3'd3, RUN,  0, 0, 0, 0);
    // Phase 2: DutyCmd 150 clamps to 100, N=50; step 20 finishes, then steps of 4.
    add_vec("map_s4", 2, 20, 3'd4, RUN, 1,   0,  50, 100);
    add_vec("map_s5", 2,  4, 3'd5, RUN, 1,  50,   0, 100);
    add_vec("map_s0", 2,  4, 3'd0, RUN, 1, 100,   0,  50);
    add_vec("map_s1", 2,  4, 3'd1, RUN, 1, 100,  50,   0);
    add_vec("map_s2", 2,  4, 3'd2, RUN, 1,  50, 100,   0);
    add_vec("map_s3", 2,  4, 3'd3, RUN, 1,   0, 100,  50);
    // Phase 3: reverse, RampStartTicks <= StepTicks enters RUN on first commutation.
    add_vec("rev_s5", 3, 4, 3'd5, RUN, 1,  50,  0, 100);
    add_vec("rev_s4", 3, 4, 3'd4, RUN, 1,   0, 50, 100);
    // Phase 4: fault scenario, first ramp step.
    add_vec("flt_s1", 4, 40, 3'd1, RAMP, 0, 0, 0, 0);
    // Phase 5..7: StepTicks 20 -> 8 mid-step, then 0.
    add_vec("st_s1", 5, 20, 3'd1, RUN, 0, 0, 0, 0);
    add_vec("st_s2", 6, 20, 3'd2, RUN, 0, 0, 0, 0);
    add_vec("st_s3", 6,  8, 3'd3, RUN, 0, 0, 0, 0);
    add_vec("st_s4", 7,  8, 3'd4, RUN, 0, 0, 0, 0);
    add_vec("st_s5", 7,  1, 3'd5, RUN, 0, 0, 0, 0);
    add_vec("st_s0", 7,  1, 3'd0, RUN, 0, 0, 0, 0);
    add_vec("st_s1b", 7, 1, 3'd1, RUN, 0, 0, 0, 0);

    Reset_n = 1'b0; Start = 0; Stop = 0; Fault = 0; FaultClear = 0; Direction = 1;
    Period = 100; DutyCmd = 30; AlignDuty = 20; AlignTicks = 10;
    RampStartTicks = 40; RampDecTicks = 10; StepTicks = 20;
    #2;
    check_out("reset", IDLE, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset_n = 1'b1;
    tick();
    check_out("idle", IDLE, 0, 0, 0, 0, 0, 0);

    // Align and ramp.
    Start = 1; tick(); Start = 0;
    check_out("align_1", ALIGN, 0, 1, 0, 0, 0, 0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      check_out($sformatf("align_%0d", i), ALIGN, 0, 1, 0, 20, 0, 50);
    end
    tick();
    check_out("ramp_r1", RAMP, 0, 1, 0, 20, 0, 50);
    since = 0;
    tick();
    check_out("ramp_r2", RAMP, 0, 1, 0, 30, 0, 50);
    load_phase(1);
    run_steps();

    // Duty mapping over all sectors, including the 5->0 wrap.
    DutyCmd = 150; StepTicks = 4;
    load_phase(2);
    run_steps();

    Stop = 1; tick(); Stop = 0;
    check_out("stop_run", IDLE, 3, 0, 0, 0, 0, 0);

    // Reverse with zero-length align.
    Direction = 0; AlignTicks = 0; RampStartTicks = 4; StepTicks = 4;
    Start = 1; tick(); Start = 0;
    check("rev_align.state", 32'(State), 32'(ALIGN));
    tick();
    check("rev_r1.state", 32'(State), 32'(RAMP));
    since = 0;
    load_phase(3);
    run_steps();

    // Stop and Start together in RUN: Stop wins, Start is dropped.
    Stop = 1; Start = 1; tick(); Stop = 0; Start = 0;
    check_out("stop_start", IDLE, 4, 0, 0, 0, 0, 0);
    tick(); tick();
    check_out("stop_start_hold", IDLE, 4, 0, 0, 0, 0, 0);

    // Fault during RAMP.
    Direction = 1; AlignTicks = 2; RampStartTicks = 40; StepTicks = 20; DutyCmd = 30;
    Start = 1; tick(); Start = 0;
    tick(); tick();
    check("flt_r1.state", 32'(State), 32'(RAMP));
    since = 0;
    load_phase(4);
    run_steps();
    tick(); tick(); tick();
    Fault = 1; tick();
    check_out("fault_enter", FLT, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    check_out("fault_hold", FLT, 1, 0, 0, 0, 0, 0);
    FaultClear = 1; tick(); FaultClear = 0;
    check_out("fault_clr_high", FLT, 1, 0, 0, 0, 0, 0);
    Fault = 0; tick();
    check_out("fault_low_noclr", FLT, 1, 0, 0, 0, 0, 0);
    FaultClear = 1; tick(); FaultClear = 0;
    check_out("fault_cleared", IDLE, 1, 0, 0, 0, 0, 0);
    tick();
    check_out("fault_idle", IDLE, 1, 0, 0, 0, 0, 0);

    // StepTicks change in RUN.
    AlignTicks = 1; RampStartTicks = 20; StepTicks = 20;
    Start = 1; tick(); Start = 0;
    tick();
    check("st_r1.state", 32'(State), 32'(RAMP));
    since = 0;
    load_phase(5);
    run_steps();
    for (int i = 0; i < 5; i++) tick();
    StepTicks = 8;
    load_phase(6);
    run_steps();
    StepTicks = 0;
    load_phase(7);
    run_steps();

    // Asynchronous reset mid-RUN, between clock edges.
    #3 Reset_n = 1'b0;
    #1;
    check_out("reset_mid_run", IDLE, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    tick(); tick(); tick();
    check_out("post_reset_idle", IDLE, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
